// File: rtl/kgp_ex_pkg.sv
// Shared op codes, forwarding-select encodings and multiplier state type for the KGP-RISC execute stage.
// The sequential multiplier is only built when EX_MUL_EN is defined.
package kgp_ex_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;
    localparam logic [3:0] OP_SLT = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_RUN  = 1'b1
    } mul_state_t;

endpackage

// File: rtl/ex_stage_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle, DATA_W cycles, low DATA_W bits kept.
// Instantiated by ex_stage only when EX_MUL_EN is defined.
module ex_mul_seq
    import kgp_ex_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              running,
    output logic              done,
    output logic [DATA_W-1:0] product
);
    localparam int CNT_W = $clog2(DATA_W);

    mul_state_t        state, state_next;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] acc, mcand, mplier;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= MUL_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            MUL_IDLE: if (start && !abort)        state_next = MUL_RUN;
            MUL_RUN:  if (abort || count == '0)   state_next = MUL_IDLE;
            default:                              state_next = MUL_IDLE;
        endcase
    end

    assign running = (state == MUL_RUN);
    assign done    = running && (count == '0);
    // product already includes this cycle's step, so it is final while done is high
    assign product = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (state == MUL_IDLE && start && !abort) begin
            count  <= CNT_W'(DATA_W - 1);
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
        end else if (running && !abort) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (count != '0) count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU and the EX/MEM pipeline register.
// Defining EX_MUL_EN adds the multi-cycle multiplier that stalls upstream via ex_busy.
module ex_stage
    import kgp_ex_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_ex_valid,
    input  logic [3:0]        id_ex_op,
    input  logic [DATA_W-1:0] id_ex_rs_data,
    input  logic [DATA_W-1:0] id_ex_rt_data,
    input  logic [DATA_W-1:0] id_ex_imm,
    input  logic              id_ex_use_imm,
    input  logic [REG_AW-1:0] id_ex_rd,
    input  logic              id_ex_regwrite,
    input  logic              id_ex_memread,
    input  logic              id_ex_memwrite,
    input  logic [1:0]        forwardA,
    input  logic [1:0]        forwardB,
    input  logic [DATA_W-1:0] mem_wb_wdata,
    input  logic              flush,
    output logic              ex_busy,
    output logic              ex_mem_valid,
    output logic              ex_mem_regwrite,
    output logic              ex_mem_memread,
    output logic              ex_mem_memwrite,
    output logic [DATA_W-1:0] ex_mem_alu_result,
    output logic [DATA_W-1:0] ex_mem_store_data,
    output logic [REG_AW-1:0] ex_mem_rd
);
    localparam int SH_W = $clog2(DATA_W);

    logic [DATA_W-1:0] opa, fwd_b, opb, alu_res;
    logic [SH_W-1:0]   shamt;

    // select 2'b11 falls into the default arm, giving EX/MEM priority
    function automatic logic [DATA_W-1:0] fwd_mux(input logic [1:0] sel, input logic [DATA_W-1:0] rf,
                                                  input logic [DATA_W-1:0] memwb, input logic [DATA_W-1:0] exmem);
        case (sel)
            FWD_RF:    return rf;
            FWD_MEMWB: return memwb;
            default:   return exmem;
        endcase
    endfunction

    assign opa   = fwd_mux(forwardA, id_ex_rs_data, mem_wb_wdata, ex_mem_alu_result);
    assign fwd_b = fwd_mux(forwardB, id_ex_rt_data, mem_wb_wdata, ex_mem_alu_result);
    assign opb   = id_ex_use_imm ? id_ex_imm : fwd_b;
    assign shamt = opb[SH_W-1:0];

    always_comb begin
        alu_res = '0;
        case (id_ex_op)
            OP_ADD:  alu_res = opa + opb;
            OP_SUB:  alu_res = opa - opb;
            OP_AND:  alu_res = opa & opb;
            OP_OR:   alu_res = opa | opb;
            OP_XOR:  alu_res = opa ^ opb;
            OP_SLL:  alu_res = opa << shamt;
            OP_SRL:  alu_res = opa >> shamt;
            OP_SRA:  alu_res = $signed(opa) >>> shamt;
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(opa) < $signed(opb))};
            default: alu_res = '0;
        endcase
    end

`ifdef EX_MUL_EN
    logic              mul_start, mul_accept, mul_running, mul_done;
    logic [DATA_W-1:0] mul_product, cap_store;
    logic [REG_AW-1:0] cap_rd;
    logic              cap_regwrite, cap_memread, cap_memwrite;

    assign mul_start  = id_ex_valid && (id_ex_op == OP_MUL);
    assign mul_accept = mul_start && !flush && !mul_running;
    assign ex_busy    = (!mul_running && mul_start) || (mul_running && !mul_done);

    ex_mul_seq #(.DATA_W(DATA_W)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .abort   (flush),
        .a       (opa),
        .b       (opb),
        .running (mul_running),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_rd       <= '0;
            cap_regwrite <= 1'b0;
            cap_memread  <= 1'b0;
            cap_memwrite <= 1'b0;
            cap_store    <= '0;
        end else if (mul_accept) begin
            cap_rd       <= id_ex_rd;
            cap_regwrite <= id_ex_regwrite;
            cap_memread  <= id_ex_memread;
            cap_memwrite <= id_ex_memwrite;
            cap_store    <= fwd_b;
        end
    end
`else
    assign ex_busy = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_mem_valid      <= 1'b0;
            ex_mem_regwrite   <= 1'b0;
            ex_mem_memread    <= 1'b0;
            ex_mem_memwrite   <= 1'b0;
            ex_mem_alu_result <= '0;
            ex_mem_store_data <= '0;
            ex_mem_rd         <= '0;
        end else if (flush) begin
            ex_mem_valid    <= 1'b0;
            ex_mem_regwrite <= 1'b0;
            ex_mem_memread  <= 1'b0;
            ex_mem_memwrite <= 1'b0;
`ifdef EX_MUL_EN
        end else if (mul_done) begin
            ex_mem_valid      <= 1'b1;
            ex_mem_regwrite   <= cap_regwrite;
            ex_mem_memread    <= cap_memread;
            ex_mem_memwrite   <= cap_memwrite;
            ex_mem_alu_result <= mul_product;
            ex_mem_store_data <= cap_store;
            ex_mem_rd         <= cap_rd;
`endif
        end else if (ex_busy || !id_ex_valid) begin
            ex_mem_valid    <= 1'b0;
            ex_mem_regwrite <= 1'b0;
            ex_mem_memread  <= 1'b0;
            ex_mem_memwrite <= 1'b0;
        end else begin
            ex_mem_valid      <= 1'b1;
            ex_mem_regwrite   <= id_ex_regwrite;
            ex_mem_memread    <= id_ex_memread;
            ex_mem_memwrite   <= id_ex_memwrite;
            ex_mem_alu_result <= alu_res;
            ex_mem_store_data <= fwd_b;
            ex_mem_rd         <= id_ex_rd;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios plus randomized traffic against a reference model.
// Multiply scenarios follow EX_MUL_EN the same way the design does.
module tb_ex_stage;
    import kgp_ex_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_ex_valid, id_ex_use_imm, id_ex_regwrite, id_ex_memread, id_ex_memwrite, flush;
    logic [3:0]    id_ex_op;
    logic [DW-1:0] id_ex_rs_data, id_ex_rt_data, id_ex_imm, mem_wb_wdata;
    logic [AW-1:0] id_ex_rd;
    logic [1:0]    forwardA, forwardB;
    logic          ex_busy, ex_mem_valid, ex_mem_regwrite, ex_mem_memread, ex_mem_memwrite;
    logic [DW-1:0] ex_mem_alu_result, ex_mem_store_data;
    logic [AW-1:0] ex_mem_rd;

    int n_cmp = 0;
    int n_err = 0;

    logic          m_valid, m_rw, m_mr, m_mw;
    logic [AW-1:0] m_rd;
    logic [DW-1:0] m_alu, m_store;

    logic [72:0] dut_pack, exp_pack;
    assign dut_pack = {ex_mem_valid, ex_mem_regwrite, ex_mem_memread, ex_mem_memwrite,
                       ex_mem_rd, ex_mem_alu_result, ex_mem_store_data};
    assign exp_pack = {m_valid, m_rw, m_mr, m_mw, m_rd, m_alu, m_store};

    ex_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
        .clk(clk), .rst(rst),
        .id_ex_valid(id_ex_valid), .id_ex_op(id_ex_op),
        .id_ex_rs_data(id_ex_rs_data), .id_ex_rt_data(id_ex_rt_data),
        .id_ex_imm(id_ex_imm), .id_ex_use_imm(id_ex_use_imm), .id_ex_rd(id_ex_rd),
        .id_ex_regwrite(id_ex_regwrite), .id_ex_memread(id_ex_memread), .id_ex_memwrite(id_ex_memwrite),
        .forwardA(forwardA), .forwardB(forwardB), .mem_wb_wdata(mem_wb_wdata), .flush(flush),
        .ex_busy(ex_busy), .ex_mem_valid(ex_mem_valid), .ex_mem_regwrite(ex_mem_regwrite),
        .ex_mem_memread(ex_mem_memread), .ex_mem_memwrite(ex_mem_memwrite),
        .ex_mem_alu_result(ex_mem_alu_result), .ex_mem_store_data(ex_mem_store_data),
        .ex_mem_rd(ex_mem_rd)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, summary not yet printed");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [DW-1:0] ref_alu(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        int sh;
        logic [DW-1:0] r;
        sh = int'(b % DW);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << sh;
            4'd6: return a >> sh;
            4'd7: begin
                r = a;
                for (int i = 0; i < sh; i++) r = {r[DW-1], r[DW-1:1]};
                return r;
            end
            4'd8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`ifdef EX_MUL_EN
            4'd9: return DW'(64'(a) * 64'(b));
`endif
            default: return '0;
        endcase
    endfunction

    function automatic logic [DW-1:0] fwd_val(input logic [1:0] sel, input logic [DW-1:0] rf);
        if (sel == 2'b00)      return rf;
        else if (sel == 2'b01) return mem_wb_wdata;
        else                   return m_alu;
    endfunction

    task automatic model_step();
        logic [DW-1:0] a, rt, b;
        if (flush || !id_ex_valid) begin
            m_valid = 1'b0; m_rw = 1'b0; m_mr = 1'b0; m_mw = 1'b0;
        end else begin
            a  = fwd_val(forwardA, id_ex_rs_data);
            rt = fwd_val(forwardB, id_ex_rt_data);
            b  = id_ex_use_imm ? id_ex_imm : rt;
            m_alu = ref_alu(id_ex_op, a, b);
            m_store = rt;
            m_rd = id_ex_rd;
            m_valid = 1'b1; m_rw = id_ex_regwrite; m_mr = id_ex_memread; m_mw = id_ex_memwrite;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        id_ex_valid = 1'b0; id_ex_op = 4'd0; id_ex_use_imm = 1'b0; id_ex_rd = '0;
        id_ex_rs_data = '0; id_ex_rt_data = '0; id_ex_imm = '0; mem_wb_wdata = '0;
        id_ex_regwrite = 1'b0; id_ex_memread = 1'b0; id_ex_memwrite = 1'b0;
        forwardA = 2'b00; forwardB = 2'b00; flush = 1'b0;
    endtask

    task automatic set_op(input logic [3:0] op, input logic [DW-1:0] rs, input logic [DW-1:0] rt,
                          input logic [DW-1:0] imm, input logic use_imm, input logic [1:0] fa,
                          input logic [1:0] fb, input logic [DW-1:0] wb, input logic [AW-1:0] rd);
        id_ex_valid = 1'b1; id_ex_op = op; id_ex_rs_data = rs; id_ex_rt_data = rt;
        id_ex_imm = imm; id_ex_use_imm = use_imm; forwardA = fa; forwardB = fb;
        mem_wb_wdata = wb; id_ex_rd = rd; id_ex_regwrite = 1'b1;
        id_ex_memread = 1'b0; id_ex_memwrite = 1'b0; flush = 1'b0;
    endtask

    task automatic apply_reset();
        idle_in();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        m_valid = 1'b0; m_rw = 1'b0; m_mr = 1'b0; m_mw = 1'b0;
        m_rd = '0; m_alu = '0; m_store = '0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_in();
        rst = 1'b1;
        #1;
        n_cmp++;
        if (dut_pack !== 73'd0 || ex_busy !== 1'b0)
            $display("FAIL reset_initial: got outputs=%h busy=%b, want 0/0", dut_pack, ex_busy);
        if (dut_pack !== 73'd0 || ex_busy !== 1'b0) n_err++;
        tick();
        rst = 1'b0;
        set_op(OP_ADD, 32'h11, 32'h22, 32'h0, 1'b0, 2'b00, 2'b00, 32'h0, 5'd7);
        tick();
        n_cmp++;
        if (ex_mem_alu_result !== 32'h33 || ex_mem_valid !== 1'b1 || ex_mem_rd !== 5'd7) begin
            n_err++;
            $display("FAIL pre_reset_add: got alu=%h valid=%b rd=%0d, want 33/1/7", ex_mem_alu_result, ex_mem_valid, ex_mem_rd);
        end
        idle_in();
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (dut_pack !== 73'd0 || ex_busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: got outputs=%h busy=%b, want 0/0", dut_pack, ex_busy);
        end
        tick();
        rst = 1'b0;
`ifdef EX_MUL_EN
        begin
            int pulses;
            set_op(OP_MUL, 32'd7, 32'd6, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 5'd3);
            tick(); tick(); tick();
            idle_in();
            #2 rst = 1'b1;
            #1;
            n_cmp++;
            if (ex_busy !== 1'b0 || ex_mem_valid !== 1'b0) begin
                n_err++;
                $display("FAIL reset_mid_mul: got busy=%b valid=%b, want 0/0", ex_busy, ex_mem_valid);
            end
            tick();
            rst = 1'b0;
            pulses = 0;
            for (int k = 0; k < DW + 8; k++) begin
                tick();
                if (ex_mem_valid || ex_busy) pulses++;
            end
            n_cmp++;
            if (pulses !== 0) begin
                n_err++;
                $display("FAIL reset_mid_mul_quiet: got %0d active cycles, want 0", pulses);
            end
        end
`endif
    endtask

    task automatic test_forward();
        logic [1:0] sels [2];
        sels[0] = 2'b10;
        sels[1] = 2'b11;
        for (int i = 0; i < 2; i++) begin
            set_op(OP_ADD, 32'd2, 32'd3, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 5'd1);
            tick();
            set_op(OP_ADD, 32'd99, 32'd3, 32'd0, 1'b0, sels[i], 2'b00, 32'd77, 5'd2);
            tick();
            n_cmp++;
            if (ex_mem_alu_result !== 32'd8 || ex_mem_valid !== 1'b1) begin
                n_err++;
                $display("FAIL fwd_exmem sel=%b: got alu=%0d valid=%b, want 8/1", sels[i], ex_mem_alu_result, ex_mem_valid);
            end
        end
        set_op(OP_SUB, 32'h30, 32'h55, 32'd0, 1'b0, 2'b00, 2'b01, 32'h10, 5'd4);
        tick();
        n_cmp++;
        if (ex_mem_alu_result !== 32'h20 || ex_mem_store_data !== 32'h10) begin
            n_err++;
            $display("FAIL fwd_memwb: got alu=%h store=%h, want 20/10", ex_mem_alu_result, ex_mem_store_data);
        end
    endtask

    task automatic test_shift_slt();
        logic [3:0]    ops  [5];
        logic [DW-1:0] as   [5];
        logic [DW-1:0] bs   [5];
        logic          imms [5];
        logic [DW-1:0] exps [5];
        ops[0] = OP_SRA; as[0] = 32'h8000_0000; bs[0] = 32'd4;  imms[0] = 1'b1; exps[0] = 32'hF800_0000;
        ops[1] = OP_SLT; as[1] = 32'hFFFF_FFFF; bs[1] = 32'd1;  imms[1] = 1'b0; exps[1] = 32'd1;
        ops[2] = OP_SLT; as[2] = 32'd1; bs[2] = 32'hFFFF_FFFF;  imms[2] = 1'b0; exps[2] = 32'd0;
        ops[3] = OP_SLL; as[3] = 32'd3; bs[3] = 32'h21;         imms[3] = 1'b1; exps[3] = 32'd6;
        ops[4] = 4'd12;  as[4] = 32'h1234; bs[4] = 32'h55;      imms[4] = 1'b0; exps[4] = 32'd0;
        for (int i = 0; i < 5; i++) begin
            set_op(ops[i], as[i], bs[i], bs[i], imms[i], 2'b00, 2'b00, 32'd0, 5'd9);
            tick();
            n_cmp++;
            if (ex_mem_alu_result !== exps[i] || ex_mem_valid !== 1'b1) begin
                n_err++;
                $display("FAIL shift_slt[%0d] op=%0d: got %h valid=%b, want %h/1", i, ops[i], ex_mem_alu_result, ex_mem_valid, exps[i]);
            end
        end
    endtask

`ifdef EX_MUL_EN
    task automatic test_mul();
        int busy_cnt, bad;
        logic [DW-1:0] ra, rb, want;
        set_op(OP_MUL, 32'd7, 32'd6, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 5'd3);
        busy_cnt = ex_busy ? 1 : 0;
        bad = 0;
        for (int k = 1; k <= DW; k++) begin
            tick();
            if (k == 1) begin forwardA = 2'b01; forwardB = 2'b10; mem_wb_wdata = 32'h1234; end
            if (ex_busy) busy_cnt++;
            if (ex_mem_valid || ex_mem_regwrite) bad++;
        end
        n_cmp++;
        if (busy_cnt !== DW || ex_busy !== 1'b0) begin
            n_err++;
            $display("FAIL mul_busy: got %0d busy cycles, busy at T+%0d=%b, want %0d/0", busy_cnt, DW, ex_busy, DW);
        end
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL mul_bubbles: got %0d non-bubble cycles, want 0", bad);
        end
        tick();
        n_cmp++;
        if (ex_mem_alu_result !== 32'd42 || ex_mem_valid !== 1'b1 || ex_mem_regwrite !== 1'b1 || ex_mem_rd !== 5'd3) begin
            n_err++;
            $display("FAIL mul_result: got alu=%0d valid=%b rw=%b rd=%0d, want 42/1/1/3", ex_mem_alu_result, ex_mem_valid, ex_mem_regwrite, ex_mem_rd);
        end
        set_op(OP_ADD, 32'd10, 32'd20, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 5'd4);
        n_cmp++;
        if (ex_busy !== 1'b0) begin
            n_err++;
            $display("FAIL mul_next_busy: got %b, want 0", ex_busy);
        end
        tick();
        n_cmp++;
        if (ex_mem_alu_result !== 32'd30 || ex_mem_valid !== 1'b1 || ex_mem_rd !== 5'd4) begin
            n_err++;
            $display("FAIL mul_next_add: got alu=%0d valid=%b rd=%0d, want 30/1/4", ex_mem_alu_result, ex_mem_valid, ex_mem_rd);
        end
        for (int r = 0; r < 3; r++) begin
            ra = $urandom; rb = (r == 0) ? 32'hFFFF_FFFF : $urandom;
            want = DW'(64'(ra) * 64'(rb));
            set_op(OP_MUL, ra, rb, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 5'(r + 10));
            for (int k = 0; k <= DW; k++) tick();
            n_cmp++;
            if (ex_mem_alu_result !== want || ex_mem_valid !== 1'b1) begin
                n_err++;
                $display("FAIL mul_rand %h*%h: got %h valid=%b, want %h/1", ra, rb, ex_mem_alu_result, ex_mem_valid, want);
            end
            idle_in();
            tick();
        end
    endtask

    task automatic test_flush();
        int bad;
        set_op(OP_MUL, 32'd7, 32'd6, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 5'd3);
        for (int k = 0; k < 10; k++) tick();
        flush = 1'b1;
        tick();
        idle_in();
        n_cmp++;
        if (ex_busy !== 1'b0 || ex_mem_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_mul: got busy=%b valid=%b at T+11, want 0/0", ex_busy, ex_mem_valid);
        end
        bad = 0;
        for (int k = 0; k < DW + 8; k++) begin
            tick();
            if (ex_mem_valid || ex_busy || ex_mem_alu_result == 32'd42) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL flush_no_write: got %0d suspicious cycles, want 0", bad);
        end
        set_op(OP_ADD, 32'd1, 32'd2, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 5'd5);
        tick();
        n_cmp++;
        if (ex_mem_alu_result !== 32'd3 || ex_mem_valid !== 1'b1) begin
            n_err++;
            $display("FAIL flush_next: got alu=%0d valid=%b, want 3/1", ex_mem_alu_result, ex_mem_valid);
        end
        idle_in();
    endtask
`else
    task automatic test_mul();
        set_op(OP_MUL, 32'd7, 32'd6, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 5'd3);
        n_cmp++;
        if (ex_busy !== 1'b0) begin
            n_err++;
            $display("FAIL mul_disabled_busy: got %b, want 0", ex_busy);
        end
        tick();
        n_cmp++;
        if (ex_mem_alu_result !== 32'd0 || ex_mem_valid !== 1'b1 || ex_mem_rd !== 5'd3) begin
            n_err++;
            $display("FAIL mul_disabled: got alu=%0d valid=%b rd=%0d, want 0/1/3", ex_mem_alu_result, ex_mem_valid, ex_mem_rd);
        end
    endtask

    task automatic test_flush();
        set_op(OP_ADD, 32'd4, 32'd5, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 5'd6);
        flush = 1'b1;
        tick();
        n_cmp++;
        if (ex_mem_valid !== 1'b0 || ex_mem_regwrite !== 1'b0) begin
            n_err++;
            $display("FAIL flush_bubble: got valid=%b rw=%b, want 0/0", ex_mem_valid, ex_mem_regwrite);
        end
        flush = 1'b0;
        tick();
        n_cmp++;
        if (ex_mem_alu_result !== 32'd9 || ex_mem_valid !== 1'b1) begin
            n_err++;
            $display("FAIL flush_next: got alu=%0d valid=%b, want 9/1", ex_mem_alu_result, ex_mem_valid);
        end
        idle_in();
    endtask
`endif

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            id_ex_valid = ($urandom_range(0, 7) != 0);
            id_ex_op = 4'($urandom_range(0, 15));
`ifdef EX_MUL_EN
            if (id_ex_op == 4'd9) id_ex_op = 4'd0;
`endif
            id_ex_rs_data = $urandom;
            id_ex_rt_data = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            id_ex_imm = $urandom;
            id_ex_use_imm = 1'($urandom_range(0, 1));
            id_ex_rd = 5'($urandom);
            id_ex_regwrite = 1'($urandom_range(0, 1));
            id_ex_memread = 1'($urandom_range(0, 1));
            id_ex_memwrite = 1'($urandom_range(0, 1));
            forwardA = 2'($urandom);
            forwardB = 2'($urandom);
            mem_wb_wdata = $urandom;
            flush = ($urandom_range(0, 15) == 0);
            n_cmp++;
            if (ex_busy !== 1'b0) begin
                n_err++;
                $display("FAIL rand_busy[%0d]: got %b, want 0", i, ex_busy);
            end
            model_step();
            tick();
            n_cmp++;
            if (dut_pack !== exp_pack) begin
                n_err++;
                $display("FAIL rand_exmem[%0d] op=%0d: got %h, want %h", i, id_ex_op, dut_pack, exp_pack);
            end
        end
        idle_in();
    endtask

    initial begin
        test_reset();
        test_forward();
        test_shift_slt();
        test_mul();
        test_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the pipelined KGP-RISC core, directly downstream of the forwarding unit. It consumes `forwardA`/`forwardB` to select each operand from one of three sources: register-file data, the EX/MEM result, or the MEM/WB write-back value. It executes the ALU operation and owns the EX/MEM pipeline register. A sequential shift-add multiplier stalls the upstream pipeline through `ex_busy` while it runs.

## Interface
- `DATA_W`, 32, datapath width.
- `REG_AW`, 5, register index width.
- `clk` in 1, the single clock.
- `rst` in 1, asynchronous, active-high reset.
- `id_ex_valid` in 1, ID/EX holds a real instruction.
- `id_ex_op` in 4, ALU op code.
- `id_ex_rs_data`, `id_ex_rt_data` in DATA_W, register-file operands.
- `id_ex_imm` in DATA_W; `id_ex_use_imm` in 1, operand B = imm.
- `id_ex_rd` in REG_AW; `id_ex_regwrite`, `id_ex_memread`, `id_ex_memwrite` in 1.
- `forwardA`, `forwardB` in 2, forwarding selects.
- `mem_wb_wdata` in DATA_W, MEM/WB write-back value.
- `flush` in 1, squash current EX work.
- `ex_busy` out 1, upstream must hold ID/EX.
- `ex_mem_valid`, `ex_mem_regwrite`, `ex_mem_memread`, `ex_mem_memwrite` out 1.
- `ex_mem_alu_result`, `ex_mem_store_data` out DATA_W.
- `ex_mem_rd` out REG_AW.

## Operation
- **Forward mux**, per operand, combinational:
  - 00: register-file data.
  - 10: internal `ex_mem_alu_result`.
  - 01: `mem_wb_wdata`.
  - 11: treated as 10 (EX/MEM has priority).
- **Operand selection:**
  - A = forwarded rs.
  - B = `id_ex_use_imm` ? imm : forwarded rt.
  - `ex_mem_store_data` = forwarded rt.
- **Ops:**
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA; shift amount = B[$clog2(DATA_W)-1:0].
  - 8 SLT, signed, result 1 or 0.
  - 9 MUL, low DATA_W bits of the product.
  - Codes 10–15 give result 0.
  - Arithmetic wraps modulo 2^DATA_W; no flags.
- **Multiplier FSM**, states IDLE and RUN:
  - IDLE → RUN when `id_ex_valid` is high, op is MUL and `flush` is low. The forwarded A and B are captured; counter = DATA_W-1; accumulator = 0.
  - In RUN, one shift-add step per cycle and the counter decrements.
  - RUN → IDLE when the counter reaches 0. EX/MEM loads the final accumulator together with the captured rd and control bits.
- **`ex_busy`** = (IDLE & `id_ex_valid` & op==MUL) | (RUN & count≠0). It is combinational.
- **EX/MEM while `ex_busy` is high:** loads a bubble (valid, regwrite, memread and memwrite all 0; data fields are don't-care but hold previous values).
- **Flush** has priority over everything:
  - EX/MEM loads a bubble.
  - The FSM returns to IDLE and any multiply is aborted with no write.
- **Invalid input:** `id_ex_valid`=0 loads a bubble.

## Timing
- **Reset:** every `ex_mem_*` output is 0, FSM is IDLE, counter and accumulator are 0, `ex_busy`=0.
- **Single-cycle ops:** operands presented in cycle T appear on EX/MEM in cycle T+1.
- **MUL accepted in cycle T:**
  - `ex_busy` is high in cycles T..T+DATA_W-1 and low in T+DATA_W.
  - The result is visible in cycle T+DATA_W+1 with `ex_mem_valid` high for exactly one cycle.
  - ID/EX still holds the MUL in cycle T+DATA_W. Because the FSM is in RUN, no restart occurs.
- **Captured operands:** forward selects and `mem_wb_wdata` are ignored during RUN; operands are those captured in cycle T.
- **Flush in a RUN cycle:** `ex_busy` is 0 from the next cycle on.
- **Reset mid-multiply:** immediate IDLE; no output pulse.

## Configuration
- **`EX_MUL_EN` defined:** multiplier FSM present, behaviour as above.
- **`EX_MUL_EN` undefined:**
  - FSM, counter and accumulator are omitted.
  - Op 9 is single-cycle with result 0.
  - `ex_busy` is tied to 0.

## Structure
- **Package `kgp_ex_pkg`:**
  - op-code localparams (OP_ADD..OP_MUL);
  - forward-select encodings (FWD_RF=2'b00, FWD_EXMEM=2'b10, FWD_MEMWB=2'b01);
  - FSM state enum.
- **Sub-module `ex_mul_seq`:** the iterative multiplier, with start/abort inputs and done/product outputs. It sits inside the `EX_MUL_EN` guard.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle → all `ex_mem_*` = 0 and `ex_busy`=0 immediately.
- **Forward from EX/MEM:** prior result 5 in EX/MEM; ADD with `forwardA`=10, rs_data=99, rt_data=3 → `ex_mem_alu_result`=8 next cycle. Repeat with `forwardA`=11 → 8.
- **Forward from MEM/WB:** SUB with `forwardB`=01, `mem_wb_wdata`=0x10, rs_data=0x30 → 0x20.
- **Shift and compare:**
  - SRA of 0x80000000 by imm 4 → 0xF8000000.
  - SLT with A=0xFFFFFFFF, B=1 → 1.
- **Multiply:** MUL 7×6 with DATA_W=32 → `ex_busy` high 32 cycles, bubbles on EX/MEM, result 42 with regwrite=1 for one cycle at T+33. The following ADD completes at T+34.
- **Flush during multiply:** `flush` pulsed at T+10 → no 42 ever written, `ex_busy`=0 from T+11, and the next instruction executes normally.
